sdram_byte_port: RTL

Avalon-MM responder that terminates the voxel GPU's byte-wide `m1` master and re-issues its accesses as 16-bit halfword transactions on the SDRAM controller's Avalon-MM slave. It sits between `voxel_gpu.m1` and the SDRAM controller and replaces the address-decode glue for the SDRAM window. Duties:
- registers the request;
- steers byte lanes;
- tracks pipelined reads in order;
- answers out-of-window accesses itself.

---
 rtl/sdram_byte_port.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sdram_byte_port.sv
// Bridges the voxel GPU's byte-wide m1 master onto the 16-bit SDRAM Avalon-MM slave.
// Reads are tracked in order; accesses outside the SDRAM window are answered locally.
module sdram_byte_port #(
    parameter logic [31:0] SDRAM_BASE  = 32'hC000_0000,
    parameter logic [31:0] SDRAM_SPAN  = 32'h0400_0000,
    parameter int          MAX_PENDING = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [7:0]  m1_writedata,
    output logic        m1_waitrequest,
    output logic [7:0]  m1_readdata,
    output logic        m1_readdatavalid,
    output logic [24:0] sdram_address,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [1:0]  sdram_byteenable,
    output logic [15:0] sdram_writedata,
    input  logic        sdram_waitrequest,
    input  logic [15:0] sdram_readdata,
    input  logic        sdram_readdatavalid
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_PENDING);

    logic [32:0] addr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;
    logic        in_window;
    logic [25:0] off;
    logic        unused_off_bit0;

    logic        slot_busy;
    logic        slot_free;
    logic        pop;
    logic        room;
    logic        accept_wr_in;
    logic        accept_rd_in;
    logic        accept_wr_out;
    logic        accept_rd_out;

    logic [MAX_PENDING-1:0] lane_q;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          pend_count;

    // 33-bit window compare so a window ending at 2^32 does not wrap.
    assign addr_ext  = {1'b0, m1_address};
    assign win_lo    = {1'b0, SDRAM_BASE};
    assign win_hi    = win_lo + {1'b0, SDRAM_SPAN};
    assign in_window = (addr_ext >= win_lo) && (addr_ext < win_hi);

    assign off             = m1_address[25:0] - SDRAM_BASE[25:0];
    assign unused_off_bit0 = off[0];

    assign slot_busy = sdram_read | sdram_write;
    assign slot_free = !slot_busy || !sdram_waitrequest;
    assign pop       = sdram_readdatavalid && (pend_count != '0);
    assign room      = (pend_count != MAX_COUNT) || pop;

    // Out-of-window reads wait for everything ahead of them to drain, keeping responses ordered.
    always_comb begin
        accept_wr_in  = 1'b0;
        accept_rd_in  = 1'b0;
        accept_wr_out = 1'b0;
        accept_rd_out = 1'b0;
        if (reset_n) begin
            accept_wr_in  = m1_write && in_window && slot_free;
            accept_rd_in  = m1_read && in_window && slot_free && room;
            accept_wr_out = m1_write && !in_window;
            accept_rd_out = m1_read && !in_window && !slot_busy && (pend_count == '0);
        end
    end

    assign m1_waitrequest = !(accept_wr_in || accept_rd_in || accept_wr_out || accept_rd_out);

    // Request slot: its registers are the SDRAM-side outputs and hold while the SDRAM stalls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sdram_read       <= 1'b0;
            sdram_write      <= 1'b0;
            sdram_address    <= '0;
            sdram_byteenable <= '0;
            sdram_writedata  <= '0;
        end else if (accept_wr_in || accept_rd_in) begin
            sdram_read       <= accept_rd_in;
            sdram_write      <= accept_wr_in;
            sdram_address    <= off[25:1];
            sdram_byteenable <= m1_address[0] ? 2'b10 : 2'b01;
            sdram_writedata  <= {m1_writedata, m1_writedata};
        end else if (!sdram_waitrequest) begin
            sdram_read  <= 1'b0;
            sdram_write <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lane_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend_count <= '0;
        end else begin
            if (accept_rd_in) begin
                lane_q[wr_ptr] <= m1_address[0];
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept_rd_in, pop})
                2'b10:   pend_count <= pend_count + CW'(1);
                2'b01:   pend_count <= pend_count - CW'(1);
                default: pend_count <= pend_count;
            endcase
        end
    end

    // A response is either a popped SDRAM read or the zero byte for an out-of-window read.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m1_readdatavalid <= 1'b0;
            m1_readdata      <= '0;
        end else begin
            m1_readdatavalid <= pop || accept_rd_out;
            if (pop) begin
                m1_readdata <= lane_q[rd_ptr] ? sdram_readdata[15:8] : sdram_readdata[7:0];
            end else begin
                m1_readdata <= 8'h00;
            end
        end
    end

endmodule
